// File: rtl/mag_sq_peak_pkg.sv
// Shared constants and the tag that rides alongside each sample through the
// magnitude-squared pipeline.
package mag_sq_peak_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 10;
    localparam int PIPE_LAT   = 3;

    // Widest bin index a tag can carry; instances must keep IDX_W <= IDX_W_MAX.
    localparam int IDX_W_MAX  = 16;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] idx;
        logic                 last;
    } tag_t;

endpackage

// File: rtl/mag_sq_peak_abs.sv
// Two's-complement magnitude: signed DATA_W-bit in, unsigned DATA_W-bit out.
// The most-negative input maps to 2^(DATA_W-1), which still fits unsigned.
module twos_abs
    import mag_sq_peak_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] x,
    output logic        [DATA_W-1:0] mag
);

    logic [DATA_W-1:0] x_u;

    assign x_u = x;
    assign mag = x[DATA_W-1] ? (~x_u + DATA_W'(1)) : x_u;

endmodule

// File: rtl/mag_sq_peak.sv
// Streaming |x|^2 with ready/valid on both sides, plus a per-frame peak
// tracker that reports the largest power bin once each frame ends.
module mag_sq_peak
    import mag_sq_peak_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                     clk_100mhz,
    input  logic                     rst_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic signed [DATA_W-1:0] real_part,
    input  logic signed [DATA_W-1:0] imag_part,
    input  logic                     last_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [2*DATA_W:0] sum,
    output logic        [IDX_W-1:0]  out_idx,
    output logic                     out_last,
    output logic                     peak_valid,
    output logic        [2*DATA_W:0] peak_mag,
    output logic        [IDX_W-1:0]  peak_idx
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int SUM_W = 2 * DATA_W + 1;

    function automatic logic [SQ_W-1:0] square(input logic [DATA_W-1:0] m);
        logic [SQ_W-1:0] w;
        w = {{DATA_W{1'b0}}, m};
        return w * w;
    endfunction

    function automatic logic [SUM_W-1:0] add_wide(input logic [SQ_W-1:0] a,
                                                  input logic [SQ_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic              advance;
    logic              accept;
    logic              out_hs;
    logic [IDX_W-1:0]  idx_cnt;
    logic [DATA_W-1:0] re_abs;
    logic [DATA_W-1:0] im_abs;

    logic [DATA_W-1:0] re_abs_p0, im_abs_p0;
    tag_t              tag_p0;
    logic              vld_p0;
    logic [SQ_W-1:0]   re_sq_p1, im_sq_p1;
    tag_t              tag_p1;
    logic              vld_p1;
    logic              vld_p2;

    logic              frame_start;
    logic              take;
    logic [SUM_W-1:0]  run_max, new_max;
    logic [IDX_W-1:0]  run_idx, new_idx;

    // A single enable freezes every stage while the output is back-pressured.
    assign ready_out = !out_valid || out_ready;
    assign advance   = ready_out;
    assign accept    = valid_in && ready_out;
    assign out_valid = vld_p2;
    assign out_hs    = out_valid && out_ready;

    twos_abs #(.DATA_W(DATA_W)) u_abs_re (.x(real_part), .mag(re_abs));
    twos_abs #(.DATA_W(DATA_W)) u_abs_im (.x(imag_part), .mag(im_abs));

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            idx_cnt  <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            sum      <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else begin
            if (accept)
                idx_cnt <= last_in ? '0 : idx_cnt + IDX_W'(1);
            if (advance) begin
                vld_p0   <= valid_in;
                vld_p1   <= vld_p0;
                vld_p2   <= vld_p1;
                // p1 -> p2: sum stage drives the output registers
                sum      <= add_wide(re_sq_p1, im_sq_p1);
                out_idx  <= IDX_W'(tag_p1.idx);
                out_last <= tag_p1.last;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (advance) begin
            // input -> p0: abs stage
            re_abs_p0 <= re_abs;
            im_abs_p0 <= im_abs;
            tag_p0    <= '{idx: IDX_W_MAX'(idx_cnt), last: last_in};
            // p0 -> p1: square stage
            re_sq_p1  <= square(re_abs_p0);
            im_sq_p1  <= square(im_abs_p0);
            tag_p1    <= tag_p0;
        end
    end

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        take    = frame_start || (sum > run_max);
        new_max = run_max;
        new_idx = run_idx;
        if (take) begin
            new_max = sum;
            new_idx = out_idx;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            frame_start <= 1'b1;
            run_max     <= '0;
            run_idx     <= '0;
            peak_valid  <= 1'b0;
            peak_mag    <= '0;
            peak_idx    <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (out_hs) begin
                if (out_last) begin
                    peak_valid  <= 1'b1;
                    peak_mag    <= new_max;
                    peak_idx    <= new_idx;
                    frame_start <= 1'b1;
                    run_max     <= '0;
                    run_idx     <= '0;
                end else begin
                    frame_start <= 1'b0;
                    run_max     <= new_max;
                    run_idx     <= new_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_mag_sq_peak.sv
// Directed bench for mag_sq_peak: vector tables with hand-computed power and
// peak results, plus latency, stall, index-wrap and mid-flight reset sequences.
module tb_mag_sq_peak;
    import mag_sq_peak_pkg::*;

    localparam int DW  = 16;
    localparam int IW  = 10;
    localparam int IW2 = 2;
    localparam int SW  = 2 * DW + 1;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 last;
        logic [SW-1:0]        sum;
        logic [IW-1:0]        idx;
        logic [SW-1:0]        pk_mag;
        logic [IW-1:0]        pk_idx;
    } vec_t;

    typedef struct {
        logic [SW-1:0] sum;
        logic [IW-1:0] idx;
        logic          last;
    } out_t;

    typedef struct {
        logic [SW-1:0] mag;
        logic [IW-1:0] idx;
    } pk_t;

    logic clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    logic                 rst_in, valid_in, ready_out, last_in, out_valid, out_ready;
    logic signed [DW-1:0] real_part, imag_part;
    logic [SW-1:0]        sum, peak_mag;
    logic [IW-1:0]        out_idx, peak_idx;
    logic                 out_last, peak_valid;

    logic                 rst_w, valid_in_w, ready_out_w, last_in_w, out_valid_w, out_ready_w;
    logic signed [DW-1:0] real_part_w, imag_part_w;
    logic [SW-1:0]        sum_w, peak_mag_w;
    logic [IW2-1:0]       out_idx_w, peak_idx_w;
    logic                 out_last_w, peak_valid_w;

    mag_sq_peak #(.DATA_W(DW), .IDX_W(IW)) u_dut (
        .clk_100mhz(clk_100mhz), .rst_in(rst_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .real_part(real_part), .imag_part(imag_part), .last_in(last_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .out_idx(out_idx), .out_last(out_last),
        .peak_valid(peak_valid), .peak_mag(peak_mag), .peak_idx(peak_idx)
    );

    mag_sq_peak #(.DATA_W(DW), .IDX_W(IW2)) u_dut_wrap (
        .clk_100mhz(clk_100mhz), .rst_in(rst_w),
        .valid_in(valid_in_w), .ready_out(ready_out_w),
        .real_part(real_part_w), .imag_part(imag_part_w), .last_in(last_in_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .sum(sum_w), .out_idx(out_idx_w), .out_last(out_last_w),
        .peak_valid(peak_valid_w), .peak_mag(peak_mag_w), .peak_idx(peak_idx_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    out_t exp_q[$];
    out_t exp_w_q[$];
    pk_t  pk_q[$];
    pk_t  pk_w_q[$];

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    // Output and peak monitors for both instances
    out_t m_o, m_ow;
    pk_t  m_p, m_pw;

    always @(negedge clk_100mhz) begin
        if (!rst_in) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("unexpected_out");
                else begin
                    m_o = exp_q.pop_front();
                    chk("sum", 64'(sum), 64'(m_o.sum));
                    chk("out_idx", 64'(out_idx), 64'(m_o.idx));
                    chk("out_last", 64'(out_last), 64'(m_o.last));
                end
            end
            if (peak_valid) begin
                if (pk_q.size() == 0) fail("unexpected_peak_valid");
                else begin
                    m_p = pk_q.pop_front();
                    chk("peak_mag", 64'(peak_mag), 64'(m_p.mag));
                    chk("peak_idx", 64'(peak_idx), 64'(m_p.idx));
                end
            end
        end
    end

    always @(negedge clk_100mhz) begin
        if (!rst_w) begin
            if (out_valid_w && out_ready_w) begin
                if (exp_w_q.size() == 0) fail("wrap_unexpected_out");
                else begin
                    m_ow = exp_w_q.pop_front();
                    chk("wrap_sum", 64'(sum_w), 64'(m_ow.sum));
                    chk("wrap_out_idx", 64'(out_idx_w), 64'(m_ow.idx));
                    chk("wrap_out_last", 64'(out_last_w), 64'(m_ow.last));
                end
            end
            if (peak_valid_w) begin
                if (pk_w_q.size() == 0) fail("wrap_unexpected_peak_valid");
                else begin
                    m_pw = pk_w_q.pop_front();
                    chk("wrap_peak_mag", 64'(peak_mag_w), 64'(m_pw.mag));
                    chk("wrap_peak_idx", 64'(peak_idx_w), 64'(m_pw.idx));
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit push);
        bit acc;
        int guard;
        valid_in  = 1'b1;
        real_part = v.re;
        imag_part = v.im;
        last_in   = v.last;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard <= 100) begin
            @(negedge clk_100mhz);
            acc = ready_out;
            @(posedge clk_100mhz);
            #1;
            guard++;
        end
        if (!acc) fail("send_accept");
        else if (push) begin
            exp_q.push_back('{v.sum, v.idx, v.last});
            if (v.last) pk_q.push_back('{v.pk_mag, v.pk_idx});
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || pk_q.size() != 0 ||
                exp_w_q.size() != 0 || pk_w_q.size() != 0) && g < 60) begin
            @(posedge clk_100mhz);
            g++;
        end
        if (g >= 60) fail("drain");
        @(posedge clk_100mhz);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t main_tab[8];
    vec_t stall_tab[8];
    vec_t wrap_tab[7];
    vec_t v1;

    initial begin
        int  n;
        bit  ok;

        main_tab = '{
            '{16'sh8000, 16'sh8000, 1'b1, 33'd2147483648, 10'd0, 33'd2147483648, 10'd0},
            '{16'sd1,    16'sd3,    1'b0, 33'd10,         10'd0, 33'd0,          10'd0},
            '{16'sd5,    16'sd5,    1'b0, 33'd50,         10'd1, 33'd0,          10'd0},
            '{-16'sd7,   16'sd1,    1'b0, 33'd50,         10'd2, 33'd0,          10'd0},
            '{-16'sd4,   -16'sd2,   1'b1, 33'd20,         10'd3, 33'd50,         10'd1},
            '{16'sd32767, 16'sh8000, 1'b0, 33'd2147418113, 10'd0, 33'd0,         10'd0},
            '{16'sd0,    16'sd0,    1'b1, 33'd0,          10'd1, 33'd2147418113, 10'd0},
            '{16'sd0,    16'sd0,    1'b1, 33'd0,          10'd0, 33'd0,          10'd0}
        };
        stall_tab = '{
            '{16'sd1,  16'sd0,  1'b0, 33'd1,  10'd0, 33'd0,  10'd0},
            '{16'sd2,  16'sd1,  1'b0, 33'd5,  10'd1, 33'd0,  10'd0},
            '{-16'sd3, 16'sd2,  1'b0, 33'd13, 10'd2, 33'd0,  10'd0},
            '{16'sd4,  -16'sd3, 1'b0, 33'd25, 10'd3, 33'd0,  10'd0},
            '{16'sd0,  -16'sd5, 1'b0, 33'd25, 10'd4, 33'd0,  10'd0},
            '{-16'sd6, -16'sd6, 1'b0, 33'd72, 10'd5, 33'd0,  10'd0},
            '{16'sd7,  16'sd0,  1'b0, 33'd49, 10'd6, 33'd0,  10'd0},
            '{-16'sd1, -16'sd8, 1'b1, 33'd65, 10'd7, 33'd72, 10'd5}
        };
        wrap_tab = '{
            '{16'sd1, 16'sd0, 1'b0, 33'd1,  10'd0, 33'd0,  10'd0},
            '{16'sd2, 16'sd0, 1'b0, 33'd4,  10'd1, 33'd0,  10'd0},
            '{16'sd3, 16'sd0, 1'b0, 33'd9,  10'd2, 33'd0,  10'd0},
            '{16'sd4, 16'sd0, 1'b0, 33'd16, 10'd3, 33'd0,  10'd0},
            '{16'sd5, 16'sd0, 1'b0, 33'd25, 10'd0, 33'd0,  10'd0},
            '{16'sd6, 16'sd0, 1'b1, 33'd36, 10'd1, 33'd36, 10'd1},
            '{16'sd2, 16'sd0, 1'b1, 33'd4,  10'd0, 33'd4,  10'd0}
        };

        rst_in = 1'b1; valid_in = 1'b0; real_part = '0; imag_part = '0;
        last_in = 1'b0; out_ready = 1'b1;
        rst_w = 1'b1; valid_in_w = 1'b0; real_part_w = '0; imag_part_w = '0;
        last_in_w = 1'b0; out_ready_w = 1'b1;
        repeat (3) @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;
        rst_w  = 1'b0;

        // Reset state
        @(negedge clk_100mhz);
        chk("rst_ready_out", 64'(ready_out), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_peak_valid", 64'(peak_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_peak_mag", 64'(peak_mag), 64'd0);
        chk("rst_peak_idx", 64'(peak_idx), 64'd0);
        @(posedge clk_100mhz);
        #1;

        // Single-sample frame (3,-4): latency, pulse timing, hold
        v1 = '{16'sd3, -16'sd4, 1'b1, 33'd25, 10'd0, 33'd25, 10'd0};
        send(v1, 1'b1);
        valid_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk_100mhz);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", 64'(n), 64'(PIPE_LAT));
        chk("first_sum", 64'(sum), 64'd25);
        @(negedge clk_100mhz);
        chk("peak_valid_next_cycle", 64'(peak_valid), 64'd1);
        @(negedge clk_100mhz);
        chk("peak_valid_one_cycle", 64'(peak_valid), 64'd0);
        chk("peak_mag_hold", 64'(peak_mag), 64'd25);
        chk("peak_idx_hold", 64'(peak_idx), 64'd0);
        @(posedge clk_100mhz);
        #1;
        drain();

        // Table run with an idle bubble after each frame
        for (int i = 0; i < 8; i++) begin
            send(main_tab[i], 1'b1);
            if (main_tab[i].last) begin
                valid_in = 1'b0;
                @(posedge clk_100mhz);
                #1;
            end
        end
        valid_in = 1'b0;
        drain();

        // Continuous stream with a 5-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send(stall_tab[i], 1'b1);
                valid_in = 1'b0;
            end
            begin
                repeat (4) @(posedge clk_100mhz);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk_100mhz);
                    chk("ready_out_stall", 64'(ready_out), 64'd0);
                end
                @(posedge clk_100mhz);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // IDX_W=2 instance: index wraps 3 -> 0, next frame restarts at 0
        for (int i = 0; i < 7; i++) begin
            valid_in_w  = 1'b1;
            real_part_w = wrap_tab[i].re;
            imag_part_w = wrap_tab[i].im;
            last_in_w   = wrap_tab[i].last;
            exp_w_q.push_back('{wrap_tab[i].sum, wrap_tab[i].idx, wrap_tab[i].last});
            if (wrap_tab[i].last) pk_w_q.push_back('{wrap_tab[i].pk_mag, wrap_tab[i].pk_idx});
            @(posedge clk_100mhz);
            #1;
        end
        valid_in_w = 1'b0;
        drain();

        // Reset with two samples in flight discards them and the partial peak
        v1 = '{16'sd100, 16'sd100, 1'b0, 33'd20000, 10'd0, 33'd0, 10'd0};
        send(v1, 1'b0);
        v1 = '{16'sd200, 16'sd0, 1'b0, 33'd40000, 10'd1, 33'd0, 10'd0};
        send(v1, 1'b0);
        valid_in = 1'b0;
        rst_in   = 1'b1;
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;
        @(negedge clk_100mhz);
        chk("ready_after_rst", 64'(ready_out), 64'd1);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_peak_mag", 64'(peak_mag), 64'd0);
        chk("midrst_peak_idx", 64'(peak_idx), 64'd0);
        ok = !(out_valid || peak_valid);
        repeat (6) begin
            @(negedge clk_100mhz);
            if (out_valid || peak_valid) ok = 1'b0;
        end
        chk("no_output_after_rst", 64'(ok), 64'd1);
        @(posedge clk_100mhz);
        #1;
        v1 = '{16'sd6, 16'sd8, 1'b0, 33'd100, 10'd0, 33'd0, 10'd0};
        send(v1, 1'b1);
        v1 = '{16'sd1, 16'sd1, 1'b1, 33'd2, 10'd1, 33'd100, 10'd0};
        send(v1, 1'b1);
        valid_in = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
